// File: rtl/ahb_line_fill_master.sv
// I-cache refill engine: one INCR4 AHB-Lite read burst per miss, assembled into a 128-bit line.
// Read-only master; a burst is cut short only by an ERROR response.
module ahb_line_fill_master #(
    parameter int         LINE_BITS = 128,
    parameter logic [3:0] HPROT_VAL = 4'b0010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req,
    input  logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_data_in,
    output logic                 mem_ready,
    output logic                 fill_err,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic                 HWRITE,
    output logic [3:0]           HPROT,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);
    localparam int         BEATS     = LINE_BITS / 32;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [27:0]          base_q, base_d;
    logic [2:0]           addr_cnt_q, addr_cnt_d;
    logic [2:0]           data_cnt_q, data_cnt_d;
    logic [31:0]          haddr_q, haddr_d;
    logic [1:0]           htrans_q, htrans_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic                 mem_ready_q, mem_ready_d;
    logic                 fill_err_q, fill_err_d;
    logic                 armed_q, armed_d;
    logic [2:0]           addr_nxt;
    logic                 data_pend;

    assign addr_nxt  = addr_cnt_q + 3'd1;
    // A data phase is outstanding whenever more addresses were accepted than words returned.
    assign data_pend = data_cnt_q < addr_cnt_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_cnt_d  = addr_cnt_q;
        data_cnt_d  = data_cnt_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        line_d      = line_q;
        mem_ready_d = 1'b0;
        fill_err_d  = fill_err_q;
        // Re-arm only after the cache has visibly dropped its request.
        armed_d     = armed_q | ~mem_req;
        case (state_q)
            S_IDLE: begin
                if (mem_req && armed_q) begin
                    base_d     = mem_addr[31:4];
                    haddr_d    = {mem_addr[31:4], 4'h0};
                    htrans_d   = TR_NONSEQ;
                    addr_cnt_d = 3'd0;
                    data_cnt_d = 3'd0;
                    fill_err_d = 1'b0;
                    armed_d    = 1'b0;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                if (HREADY) begin
                    if (htrans_q != TR_IDLE) begin
                        addr_cnt_d = addr_nxt;
                        if (addr_cnt_q == 3'(BEATS - 1)) begin
                            htrans_d = TR_IDLE;
                        end else begin
                            htrans_d = TR_SEQ;
                            haddr_d  = {base_q, addr_nxt[1:0], 2'b00};
                        end
                    end
                    if (data_pend) begin
                        if (HRESP) begin
                            htrans_d    = TR_IDLE;
                            fill_err_d  = 1'b1;
                            mem_ready_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            for (int k = 0; k < BEATS; k++) begin
                                if (data_cnt_q == 3'(k)) line_d[32*k +: 32] = HRDATA;
                            end
                            data_cnt_d = data_cnt_q + 3'd1;
                            if (data_cnt_q == 3'(BEATS - 1)) begin
                                mem_ready_d = 1'b1;
                                state_d     = S_DONE;
                            end
                        end
                    end
                end else if (HRESP && data_pend) begin
                    // First ERROR cycle: withdraw the pending address and cancel the rest.
                    htrans_d = TR_IDLE;
                    state_d  = S_ERR;
                end
            end
            S_ERR: begin
                htrans_d = TR_IDLE;
                if (HREADY) begin
                    fill_err_d  = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                fill_err_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_cnt_q  <= '0;
            data_cnt_q  <= '0;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            line_q      <= '0;
            mem_ready_q <= 1'b0;
            fill_err_q  <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_cnt_q  <= addr_cnt_d;
            data_cnt_q  <= data_cnt_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            line_q      <= line_d;
            mem_ready_q <= mem_ready_d;
            fill_err_q  <= fill_err_d;
            armed_q     <= armed_d;
        end
    end

    assign mem_data_in = line_q;
    assign mem_ready   = mem_ready_q;
    assign fill_err    = fill_err_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HBURST      = 3'b011;
    assign HSIZE       = 3'b010;
    assign HWRITE      = 1'b0;
    assign HPROT       = HPROT_VAL;
endmodule

// File: tb/tb_ahb_line_fill_master.sv
// Bench for ahb_line_fill_master: AHB slave model with per-beat waits/error, scoreboard of expected lines.
module tb_ahb_line_fill_master;
    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data_in;
    logic         mem_ready, fill_err;
    logic [31:0]  HADDR, HRDATA;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST, HSIZE;
    logic         HWRITE, HREADY, HRESP;
    logic [3:0]   HPROT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] line;
        logic         err;
        int           lat;
    } exp_t;
    exp_t sb[$];

    // slave configuration and state
    int          waits[4];
    int          err_beat;
    logic [31:0] salt;
    logic        dp, eph;
    logic [31:0] da;
    int          wcnt;
    logic [127:0] line_model;

    ahb_line_fill_master dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready), .fill_err(fill_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HPROT(HPROT), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a, input logic [31:0] s);
        return {a[15:0] ^ s[15:0], ~a[15:0] ^ s[31:16]};
    endfunction

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'hDEAD_BEEF;
        if (dp) begin
            if (int'(da[3:2]) == err_beat) begin
                HRESP  = 1'b1;
                HREADY = eph;
            end else if (wcnt < waits[da[3:2]]) begin
                HREADY = 1'b0;
            end else begin
                HRDATA = word_of(da, salt);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp <= 1'b0; da <= '0; wcnt <= 0; eph <= 1'b0;
        end else if (HREADY) begin
            dp <= HTRANS[1]; da <= HADDR; wcnt <= 0; eph <= 1'b0;
        end else begin
            wcnt <= wcnt + 1; eph <= 1'b1;
        end
    end

    // Runs one fill; hold keeps mem_req high after mem_ready for the caller to manage.
    task automatic do_fill(input logic [31:0] addr, input int lat_exp, input int eb, input bit hold);
        exp_t        e, got;
        logic [31:0] base, aq[$];
        logic [1:0]  tq[$];
        int          n, nacc;
        bit          done;
        logic        p_ok, p_hready, p_hresp;
        logic [31:0] p_haddr;
        logic [1:0]  p_htrans;
        base     = {addr[31:4], 4'h0};
        salt     = $urandom;
        err_beat = eb;
        nacc     = (eb >= 0) ? eb + 1 : 4;
        for (int k = 0; k < 4; k++)
            if (eb < 0 || k < eb) line_model[32*k +: 32] = word_of(base + 32'(4*k), salt);
        e.line = line_model; e.err = (eb >= 0); e.lat = lat_exp;
        sb.push_back(e);
        @(negedge clk);
        mem_req = 1'b1; mem_addr = addr;
        @(posedge clk);
        n = 0; done = 0; p_ok = 0;
        p_hready = 1'b1; p_hresp = 1'b0; p_haddr = '0; p_htrans = '0;
        while (!done && n < 40) begin
            @(negedge clk);
            if (p_ok && !p_hready && p_hresp) begin
                checks++;
                if (HTRANS !== 2'b00) begin
                    errors++; $display("FAIL err_cancel htrans got %b exp 00", HTRANS);
                end
            end else if (p_ok && !p_hready && p_htrans != 2'b00) begin
                checks++;
                if (HADDR !== p_haddr || HTRANS !== p_htrans) begin
                    errors++; $display("FAIL freeze got %h/%b exp %h/%b", HADDR, HTRANS, p_haddr, p_htrans);
                end
            end
            if (HREADY && HTRANS[1]) begin aq.push_back(HADDR); tq.push_back(HTRANS); end
            p_ok = 1; p_hready = HREADY; p_hresp = HRESP; p_haddr = HADDR; p_htrans = HTRANS;
            if (mem_ready) done = 1;
            else begin @(posedge clk); n++; end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL timeout no mem_ready for addr %h", addr);
            void'(sb.pop_front());
        end else begin
            got = sb.pop_front();
            checks++;
            if (mem_data_in !== got.line) begin
                errors++; $display("FAIL line got %h exp %h", mem_data_in, got.line);
            end
            checks++;
            if (fill_err !== got.err) begin
                errors++; $display("FAIL fill_err got %b exp %b", fill_err, got.err);
            end
            checks++;
            if (n != got.lat) begin
                errors++; $display("FAIL latency got %0d exp %0d", n, got.lat);
            end
        end
        checks++;
        if (aq.size() != nacc) begin
            errors++; $display("FAIL addr_count got %0d exp %0d", aq.size(), nacc);
        end else begin
            for (int k = 0; k < nacc; k++) begin
                checks++;
                if (aq[k] !== base + 32'(4*k) || tq[k] !== ((k == 0) ? 2'b10 : 2'b11)) begin
                    errors++;
                    $display("FAIL beat%0d addr got %h/%b exp %h/%b", k, aq[k], tq[k],
                             base + 32'(4*k), (k == 0) ? 2'b10 : 2'b11);
                end
            end
        end
        if (!hold) mem_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b0 || mem_data_in !== line_model) begin
            errors++; $display("FAIL pulse/hold got ready=%b line=%h exp 0/%h", mem_ready, mem_data_in, line_model);
        end
        for (int k = 0; k < 4; k++) waits[k] = 0;
        err_beat = -1;
    endtask

    task automatic test_reset();
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || mem_data_in !== 128'h0 ||
            mem_ready !== 1'b0 || fill_err !== 1'b0) begin
            errors++; $display("FAIL reset_state got htrans=%b haddr=%h line=%h rdy=%b err=%b",
                               HTRANS, HADDR, mem_data_in, mem_ready, fill_err);
        end
        checks++;
        if (HBURST !== 3'b011 || HSIZE !== 3'b010 || HWRITE !== 1'b0 || HPROT !== 4'b0010) begin
            errors++; $display("FAIL ctrl got burst=%b size=%b write=%b prot=%b exp 011/010/0/0010",
                               HBURST, HSIZE, HWRITE, HPROT);
        end
    endtask

    task automatic test_zero_wait();
        do_fill(32'h0000_1234, 5, -1, 0);
    endtask

    task automatic test_wait_states();
        waits[1] = 2;
        do_fill(32'h0000_1234, 7, -1, 0);
    endtask

    task automatic test_error();
        do_fill(32'h0000_5670, 5, 2, 0);
    endtask

    task automatic test_back_to_back();
        do_fill(32'h0000_2000, 5, -1, 1);
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b00) begin
            errors++; $display("FAIL held_req_refill htrans got %b exp 00", HTRANS);
        end
        mem_req = 1'b0;
        do_fill(32'h0000_2010, 5, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        salt = $urandom;
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 32'h0000_3000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || mem_data_in !== 128'h0 || mem_ready !== 1'b0 || HADDR !== 32'h0) begin
            errors++; $display("FAIL reset_mid got htrans=%b line=%h rdy=%b haddr=%h",
                               HTRANS, mem_data_in, mem_ready, HADDR);
        end
        mem_req = 1'b0;
        line_model = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_ready) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL reset_no_ready got mem_ready=1 exp 0");
        end
        do_fill(32'h0000_3000, 5, -1, 0);
    endtask

    task automatic test_top_of_memory();
        do_fill(32'hFFFF_FFF8, 5, -1, 0);
    endtask

    initial begin
        rst = 1'b1; mem_req = 1'b0; mem_addr = '0;
        err_beat = -1; salt = '0; line_model = '0;
        for (int k = 0; k < 4; k++) waits[k] = 0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_zero_wait();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_reset_mid_burst();
        test_top_of_memory();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
